// File: rtl/apb_master.sv
// APB requester: takes one command at a time and runs it as an APB SETUP/ACCESS transfer,
// returning a single-cycle response pulse. Optional timeout aborts a stalled completer.
module apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_slverr,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e              state_q;
    logic [31:0]         wait_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_slverr_q;
    logic                rsp_timeout_q;
    logic                timeout_hit;

    // The current ACCESS cycle is the TIMEOUT-th consecutive one without pready.
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == TIMEOUT - 1);

    assign cmd_ready   = (state_q == StIdle) && presetn;

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q       <= StIdle;
            wait_q        <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        paddr_q   <= cmd_addr;
                        pwdata_q  <= cmd_wdata;
                        pwrite_q  <= cmd_write;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (pready) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_slverr_q  <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        // Only clean reads return data.
                        rsp_rdata_q   <= (!pwrite_q && !pslverr) ? prdata : '0;
                        state_q       <= StResp;
                    end else if (timeout_hit) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_slverr_q  <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        state_q       <= StResp;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                StResp: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a 32-word RAM completer that supports wait states,
// an out-of-range error response and an indefinite stall.
module tb_apb_master;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    apb_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Completer model
    logic [31:0] mem [32];
    int          acc_cnt = 0;
    int          wait_states = 0;
    bit          stall = 1'b0;

    assign pready  = psel && penable && !stall && (acc_cnt == wait_states);
    assign prdata  = (paddr < 32) ? mem[paddr[4:0]] : 32'h0;
    assign pslverr = pready && (paddr >= 32);

    always @(posedge pclk) begin
        acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
        if (!presetn) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
        end else if (psel && penable && pready && pwrite && paddr < 32) begin
            mem[paddr[4:0]] <= pwdata;
        end
    end

    // Results of the last transfer
    int          lat;
    int          n_psel;
    int          n_pen;
    int          unstable;
    logic [31:0] r_rdata;
    logic        r_slverr;
    logic        r_timeout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with cmd_ready high; returns at the negedge of the rsp_valid cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        bit got;
        int n;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = 32'hFFFF_FFFF;
        cmd_wdata = ~wd;
        n_psel = 0; n_pen = 0; unstable = 0; got = 1'b0; n = 0;
        r_rdata = 32'hX; r_slverr = 1'bX; r_timeout = 1'bX;
        while (!got && n < 100) begin
            n++;
            if (psel) begin
                n_psel++;
                if (paddr !== addr || pwrite !== wr || pwdata !== wd) unstable++;
            end
            if (penable) n_pen++;
            if (rsp_valid) begin
                got       = 1'b1;
                r_rdata   = rsp_rdata;
                r_slverr  = rsp_slverr;
                r_timeout = rsp_timeout;
            end else begin
                @(negedge pclk);
            end
        end
        lat = n;
    endtask

    task automatic after_rsp(input string tag);
        @(negedge pclk);
        check({tag, "_rsp_pulse_once"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, "_ready_again"}, {31'h0, cmd_ready}, 32'h1);
        check({tag, "_psel_idle"}, {31'h0, psel}, 32'h0);
    endtask

    int acc_idx [8];
    int n_acc;
    int n_rsp;

    initial begin
        presetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        repeat (2) @(negedge pclk);

        // Reset state
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        check("rst_psel", {31'h0, psel}, 32'h0);
        check("rst_penable", {31'h0, penable}, 32'h0);
        check("rst_pwrite", {31'h0, pwrite}, 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_flags", {30'h0, rsp_slverr, rsp_timeout}, 32'h0);
        presetn = 1'b1;
        #1;
        check("rel_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // Write 0x5 <- 0xDEADBEEF, no wait states
        xfer(1'b1, 32'h5, 32'hDEAD_BEEF);
        check("wr_latency", lat, 32'd3);
        check("wr_psel_cycles", n_psel, 32'd2);
        check("wr_penable_cycles", n_pen, 32'd1);
        check("wr_stable", unstable, 32'd0);
        check("wr_slverr", {31'h0, r_slverr}, 32'h0);
        check("wr_timeout", {31'h0, r_timeout}, 32'h0);
        check("wr_rdata", r_rdata, 32'h0);
        check("wr_mem", mem[5], 32'hDEAD_BEEF);
        after_rsp("wr");

        // Read it back
        xfer(1'b0, 32'h5, 32'h0BAD_F00D);
        check("rd_latency", lat, 32'd3);
        check("rd_rdata", r_rdata, 32'hDEAD_BEEF);
        check("rd_slverr", {31'h0, r_slverr}, 32'h0);
        check("rd_stable", unstable, 32'd0);
        after_rsp("rd");

        // Out-of-range read: slave error, data suppressed
        xfer(1'b0, 32'h40, 32'h0);
        check("err_latency", lat, 32'd3);
        check("err_slverr", {31'h0, r_slverr}, 32'h1);
        check("err_timeout", {31'h0, r_timeout}, 32'h0);
        check("err_rdata", r_rdata, 32'h0);
        after_rsp("err");

        // Completer never ready: abort after 16 ACCESS cycles
        stall = 1'b1;
        xfer(1'b0, 32'h7, 32'h0);
        check("to_latency", lat, 32'd18);
        check("to_penable_cycles", n_pen, 32'd16);
        check("to_psel_cycles", n_psel, 32'd17);
        check("to_timeout", {31'h0, r_timeout}, 32'h1);
        check("to_slverr", {31'h0, r_slverr}, 32'h1);
        check("to_rdata", r_rdata, 32'h0);
        check("to_stable", unstable, 32'd0);
        stall = 1'b0;
        after_rsp("to");

        // Three wait states: completes on the 4th ACCESS cycle
        wait_states = 3;
        xfer(1'b1, 32'h9, 32'h1234_5678);
        check("ws_wr_latency", lat, 32'd6);
        check("ws_wr_penable_cycles", n_pen, 32'd4);
        check("ws_wr_stable", unstable, 32'd0);
        check("ws_wr_flags", {30'h0, r_slverr, r_timeout}, 32'h0);
        after_rsp("ws_wr");
        xfer(1'b0, 32'h9, 32'h0);
        check("ws_rd_latency", lat, 32'd6);
        check("ws_rd_rdata", r_rdata, 32'h1234_5678);
        after_rsp("ws_rd");
        wait_states = 0;

        // Reset during ACCESS drops the transfer
        stall = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h3;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("mid_in_access", {30'h0, psel, penable}, 32'h3);
        presetn = 1'b0;
        @(negedge pclk);
        check("mid_psel_dropped", {30'h0, psel, penable}, 32'h0);
        check("mid_no_rsp", {31'h0, rsp_valid}, 32'h0);
        check("mid_ready_in_rst", {31'h0, cmd_ready}, 32'h0);
        presetn = 1'b1;
        stall   = 1'b0;
        #1;
        check("mid_ready_release", {31'h0, cmd_ready}, 32'h1);
        n_rsp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            if (rsp_valid) n_rsp++;
        end
        check("mid_no_late_rsp", n_rsp, 32'd0);

        // Back-to-back: cmd_valid held high
        n_acc = 0;
        n_rsp = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h5;
        for (int i = 0; i < 13; i++) begin
            if (cmd_ready && n_acc < 8) begin
                acc_idx[n_acc] = i;
                n_acc++;
            end
            if (rsp_valid) n_rsp++;
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        repeat (4) @(negedge pclk);
        check("b2b_accepts", n_acc, 32'd4);
        check("b2b_rsp_pulses", n_rsp, 32'd3);
        for (int k = 1; k < 4; k++) begin
            if (k < n_acc) check("b2b_spacing", acc_idx[k] - acc_idx[k-1], 32'd4);
        end
        check("b2b_idle", {30'h0, psel, cmd_ready}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
